ldst_mmio_bridge: RTL and testbench

//  Sits directly downstream of the CPU load/store port (port 2).

---
 rtl/ldst_mmio_bridge_pkg.sv | 42 ++++
 rtl/ldst_mmio_bridge_if.sv | 39 +++
 rtl/ldst_mmio_bridge_tx_fifo.sv | 75 +++++++
 rtl/ldst_mmio_bridge.sv | 126 ++++++++++++
 tb/tb_ldst_mmio_bridge.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ldst_mmio_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ldst_mmio_bridge_pkg
//  Brief   : MMIO offsets, register bit positions and register-file struct
//            shared by the load/store MMIO bridge.
//  Revision: 1.0 - initial release
// ============================================================================
package ldst_mmio_bridge_pkg;

    // Register offsets within the MMIO window (low address byte)
    localparam logic [7:0] OFS_GPIO   = 8'd0;
    localparam logic [7:0] OFS_COUNT  = 8'd1;
    localparam logic [7:0] OFS_CMP    = 8'd2;
    localparam logic [7:0] OFS_CTRL   = 8'd3;
    localparam logic [7:0] OFS_STATUS = 8'd4;
    localparam logic [7:0] OFS_TXDATA = 8'd5;
    localparam logic [7:0] OFS_ACK    = 8'd6;

    // CTRL bits
    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;

    // ACK bits (write-one-to-clear)
    localparam int ACK_IRQ = 0;
    localparam int ACK_OVF = 1;

    // STATUS bits; bits [3:0] carry the saturated FIFO count
    localparam int STAT_EMPTY = 4;
    localparam int STAT_FULL  = 5;
    localparam int STAT_IRQ   = 6;
    localparam int STAT_OVF   = 7;

    // CPU-visible read/write registers
    typedef struct packed {
        logic [15:0] gpio;
        logic [15:0] count;
        logic [15:0] cmp;
        logic [15:0] ctrl;
    } mmio_regs_t;

endpackage
`default_nettype wire

// File: rtl/ldst_mmio_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module  : ldst_mmio_bridge_if
//  Brief   : Load/store port, RAM port, GPIO, TX stream and IRQ bundle.
//            Prefixes are relative to the bridge (slave side).
//  Revision: 1.0 - initial release
// ============================================================================
interface ldst_mmio_bridge_if;
    logic [15:0] i_ldst_addr;
    logic [15:0] i_ldst_wrdata;
    logic        i_ldst_rd;
    logic        i_ldst_wr;
    logic [15:0] o_ldst_rddata;
    logic [15:0] o_ram_addr;
    logic [15:0] o_ram_wrdata;
    logic        o_ram_rd;
    logic        o_ram_wr;
    logic [15:0] i_ram_rddata;
    logic [15:0] o_gpio;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_irq;

    // Bridge side
    modport slave (
        input  i_ldst_addr, i_ldst_wrdata, i_ldst_rd, i_ldst_wr, i_ram_rddata, i_tx_ready,
        output o_ldst_rddata, o_ram_addr, o_ram_wrdata, o_ram_rd, o_ram_wr,
               o_gpio, o_tx_data, o_tx_valid, o_irq
    );

    // CPU / RAM / sink side
    modport master (
        output i_ldst_addr, i_ldst_wrdata, i_ldst_rd, i_ldst_wr, i_ram_rddata, i_tx_ready,
        input  o_ldst_rddata, o_ram_addr, o_ram_wrdata, o_ram_rd, o_ram_wr,
               o_gpio, o_tx_data, o_tx_valid, o_irq
    );
endinterface
`default_nettype wire

// File: rtl/ldst_mmio_bridge_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : ldst_mmio_bridge_tx_fifo
//  Brief   : Synchronous TX FIFO with sticky overflow flag. No fall-through:
//            a byte pushed into an empty FIFO appears the following cycle.
//  Revision: 1.0 - initial release
// ============================================================================
module ldst_mmio_bridge_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_ovf_clr,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_count,
    output logic                            o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop     = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken
    assign w_push_ok = i_push & (~o_full | w_pop);
    assign w_drop    = i_push & o_full & ~w_pop;

    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and sticky overflow (set wins over clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)         r_ovf <= 1'b1;
            else if (i_ovf_clr) r_ovf <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/ldst_mmio_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : ldst_mmio_bridge
//  Brief   : Routes CPU load/store accesses to RAM or to an MMIO block
//            (GPIO, compare timer with IRQ, TX FIFO). Loads return data one
//            cycle after the strobe for both targets, matching RAM latency.
//  Revision: 1.0 - initial release
// ============================================================================
module ldst_mmio_bridge
    import ldst_mmio_bridge_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ldst_mmio_bridge_if.slave     bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mmio_regs_t  r_regs;
    logic        r_irq_pending;
    logic        r_rd_mmio;
    logic        r_rd_ram;
    logic [15:0] r_rd_q;

    logic        w_is_mmio;
    logic [7:0]  w_ofs;
    logic        w_mmio_wr;
    logic        w_wr_gpio, w_wr_count, w_wr_cmp, w_wr_ctrl, w_wr_txdata, w_wr_ack;
    logic        w_match;
    logic [15:0] w_rd_val;
    logic [3:0]  w_stat_cnt;
    logic        w_fifo_full, w_fifo_empty, w_fifo_ovf;
    logic [CW-1:0] w_fifo_count;

    // Address decode and RAM pass-through
    assign w_is_mmio         = (bus.i_ldst_addr >= MMIO_BASE);
    assign w_ofs             = bus.i_ldst_addr[7:0];
    assign bus.o_ram_addr    = bus.i_ldst_addr;
    assign bus.o_ram_wrdata  = bus.i_ldst_wrdata;
    assign bus.o_ram_rd      = bus.i_ldst_rd & ~w_is_mmio;
    assign bus.o_ram_wr      = bus.i_ldst_wr & ~w_is_mmio;

    assign w_mmio_wr   = bus.i_ldst_wr & w_is_mmio;
    assign w_wr_gpio   = w_mmio_wr & (w_ofs == OFS_GPIO);
    assign w_wr_count  = w_mmio_wr & (w_ofs == OFS_COUNT);
    assign w_wr_cmp    = w_mmio_wr & (w_ofs == OFS_CMP);
    assign w_wr_ctrl   = w_mmio_wr & (w_ofs == OFS_CTRL);
    assign w_wr_txdata = w_mmio_wr & (w_ofs == OFS_TXDATA);
    assign w_wr_ack    = w_mmio_wr & (w_ofs == OFS_ACK);

    // Compare match only counts while the timer runs; CMP = 0 disables it
    assign w_match = r_regs.ctrl[CTRL_TIMER_EN] & (r_regs.cmp != 16'h0000) &
                     (r_regs.count == r_regs.cmp);

    // Register file and timer; a CPU write to COUNT overrides increment and match
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs        <= '0;
            r_irq_pending <= 1'b0;
        end else begin
            if (w_wr_gpio) r_regs.gpio <= bus.i_ldst_wrdata;
            if (w_wr_cmp)  r_regs.cmp  <= bus.i_ldst_wrdata;
            if (w_wr_ctrl) r_regs.ctrl <= bus.i_ldst_wrdata;
            if (w_wr_count)                          r_regs.count <= 16'h0000;
            else if (w_match)                        r_regs.count <= 16'h0000;
            else if (r_regs.ctrl[CTRL_TIMER_EN])     r_regs.count <= r_regs.count + 16'd1;
            if (w_match && !w_wr_count)                          r_irq_pending <= 1'b1;
            else if (w_wr_ack && bus.i_ldst_wrdata[ACK_IRQ])     r_irq_pending <= 1'b0;
        end
    end

    ldst_mmio_bridge_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_wr_txdata),
        .i_push_data (bus.i_ldst_wrdata[7:0]),
        .i_pop       (bus.o_tx_valid & bus.i_tx_ready),
        .i_ovf_clr   (w_wr_ack & bus.i_ldst_wrdata[ACK_OVF]),
        .o_data      (bus.o_tx_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_ovf       (w_fifo_ovf)
    );

    assign bus.o_tx_valid = ~w_fifo_empty;
    assign bus.o_gpio     = r_regs.gpio;
    assign bus.o_irq      = r_irq_pending & r_regs.ctrl[CTRL_IRQ_EN];

    // MMIO read mux from current state, so a same-cycle write is not visible
    always_comb begin
        w_rd_val   = 16'h0000;
        w_stat_cnt = (32'(w_fifo_count) > 32'd15) ? 4'hF : 4'(w_fifo_count);
        case (w_ofs)
            OFS_GPIO:   w_rd_val = r_regs.gpio;
            OFS_COUNT:  w_rd_val = r_regs.count;
            OFS_CMP:    w_rd_val = r_regs.cmp;
            OFS_CTRL:   w_rd_val = r_regs.ctrl;
            OFS_STATUS: w_rd_val = {8'h00, w_fifo_ovf, r_irq_pending, w_fifo_full,
                                    w_fifo_empty, w_stat_cnt};
            default:    w_rd_val = 16'h0000;
        endcase
    end

    // Load-return pipeline: remember the target and capture MMIO data one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_mmio <= 1'b0;
            r_rd_ram  <= 1'b0;
            r_rd_q    <= 16'h0000;
        end else begin
            r_rd_mmio <= bus.i_ldst_rd & w_is_mmio;
            r_rd_ram  <= bus.i_ldst_rd & ~w_is_mmio;
            if (bus.i_ldst_rd && w_is_mmio) r_rd_q <= w_rd_val;
        end
    end

    assign bus.o_ldst_rddata = r_rd_mmio ? r_rd_q :
                               (r_rd_ram ? bus.i_ram_rddata : 16'h0000);
endmodule
`default_nettype wire

// File: tb/tb_ldst_mmio_bridge.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ldst_mmio_bridge
//  Brief   : Directed self-checking bench for ldst_mmio_bridge with a small
//            1-cycle-latency RAM model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ldst_mmio_bridge;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ldst_mmio_bridge_if bus ();

    ldst_mmio_bridge #(
        .MMIO_BASE  (16'hFF00),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with 1-cycle read latency
    logic [15:0] ram_mem [256];
    always @(posedge clk) begin
        if (bus.o_ram_wr) ram_mem[bus.o_ram_addr[7:0]] <= bus.o_ram_wrdata;
        if (bus.o_ram_rd) bus.i_ram_rddata <= ram_mem[bus.o_ram_addr[7:0]];
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.i_ldst_addr   = a;
        bus.i_ldst_wrdata = d;
        bus.i_ldst_wr     = 1'b1;
        tick();
        bus.i_ldst_wr     = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.i_ldst_addr = a;
        bus.i_ldst_rd   = 1'b1;
        tick();
        bus.i_ldst_rd   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.i_ldst_addr   = 16'h0000;
        bus.i_ldst_wrdata = 16'h0000;
        bus.i_ldst_rd     = 1'b0;
        bus.i_ldst_wr     = 1'b0;
        bus.i_tx_ready    = 1'b0;
        bus.i_ram_rddata  = 16'h0000;
        tick();
        tick();

        // Reset state
        chk("rst_rddata", bus.o_ldst_rddata, 16'h0000);
        chk("rst_gpio",   bus.o_gpio, 16'h0000);
        chk("rst_txvalid", {15'h0, bus.o_tx_valid}, 16'h0000);
        chk("rst_txdata", {8'h00, bus.o_tx_data}, 16'h0000);
        chk("rst_irq",    {15'h0, bus.o_irq}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 1. RAM write/readback
        bus.i_ldst_addr   = 16'h0010;
        bus.i_ldst_wrdata = 16'h1234;
        bus.i_ldst_wr     = 1'b1;
        #1;
        chk("ram_wr_strobe", {15'h0, bus.o_ram_wr}, 16'h0001);
        chk("ram_addr", bus.o_ram_addr, 16'h0010);
        tick();
        bus.i_ldst_wr = 1'b0;
        #1;
        chk("ram_wr_drop", {15'h0, bus.o_ram_wr}, 16'h0000);
        rd(16'h0010);
        chk("ram_rddata", bus.o_ldst_rddata, 16'h1234);
        chk("ram_no_gpio", bus.o_gpio, 16'h0000);

        // 2. GPIO write/read, then simultaneous rd+wr returns old value
        wr(16'hFF00, 16'hA5A5);
        chk("gpio_out", bus.o_gpio, 16'hA5A5);
        chk("gpio_no_ramwr", {15'h0, bus.o_ram_wr}, 16'h0000);
        rd(16'hFF00);
        chk("gpio_rd", bus.o_ldst_rddata, 16'hA5A5);
        bus.i_ldst_rd = 1'b1;
        wr(16'hFF00, 16'h1111);
        bus.i_ldst_rd = 1'b0;
        chk("rdwr_old", bus.o_ldst_rddata, 16'hA5A5);
        chk("rdwr_new", bus.o_gpio, 16'h1111);
        rd(16'hFF09);
        chk("unmapped_rd", bus.o_ldst_rddata, 16'h0000);

        // 3. Timer: CMP=5, enable timer+irq; successive reads see 0..5 then 0
        wr(16'hFF02, 16'h0005);
        wr(16'hFF03, 16'h0003);
        for (int i = 0; i < 7; i++) begin
            rd(16'hFF01);
            chk("count_run", bus.o_ldst_rddata, (i == 6) ? 16'h0000 : 16'(i));
        end
        chk("irq_set", {15'h0, bus.o_irq}, 16'h0001);
        rd(16'hFF04);
        chk("status_irq", bus.o_ldst_rddata, 16'h0050);
        wr(16'hFF06, 16'h0001);
        chk("irq_ack", {15'h0, bus.o_irq}, 16'h0000);
        wr(16'hFF03, 16'h0000);
        wr(16'hFF01, 16'h1234);
        rd(16'hFF01);
        chk("count_wr_clr", bus.o_ldst_rddata, 16'h0000);
        chk("irq_stays_low", {15'h0, bus.o_irq}, 16'h0000);

        // 4. Fill FIFO with 9 bytes while sink stalled
        for (int i = 1; i <= 9; i++) wr(16'hFF05, 16'(i));
        rd(16'hFF04);
        chk("fifo_full_status", bus.o_ldst_rddata, 16'h00A8);
        chk("fifo_head", {8'h00, bus.o_tx_data}, 16'h0001);

        // 5. Push 0x55 while full together with a pop
        bus.i_tx_ready = 1'b1;
        wr(16'hFF05, 16'h0055);
        bus.i_tx_ready = 1'b0;
        rd(16'hFF04);
        chk("full_pushpop_status", bus.o_ldst_rddata, 16'h00A8);
        chk("full_pushpop_head", {8'h00, bus.o_tx_data}, 16'h0002);

        // Drain: 0x02..0x08 then 0x55
        bus.i_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {15'h0, bus.o_tx_valid}, 16'h0001);
            chk("drain_data", {8'h00, bus.o_tx_data}, (i < 7) ? 16'(i + 2) : 16'h0055);
            tick();
        end
        chk("drained_valid", {15'h0, bus.o_tx_valid}, 16'h0000);
        chk("drained_data", {8'h00, bus.o_tx_data}, 16'h0000);
        bus.i_tx_ready = 1'b0;
        wr(16'hFF06, 16'h0002);
        rd(16'hFF04);
        chk("ovf_cleared", bus.o_ldst_rddata, 16'h0010);

        // Push into empty FIFO with ready high: no fall-through
        bus.i_tx_ready = 1'b1;
        bus.i_ldst_addr   = 16'hFF05;
        bus.i_ldst_wrdata = 16'h00C3;
        bus.i_ldst_wr     = 1'b1;
        #1;
        chk("no_fallthrough", {15'h0, bus.o_tx_valid}, 16'h0000);
        tick();
        bus.i_ldst_wr  = 1'b0;
        bus.i_tx_ready = 1'b0;
        chk("push_empty_valid", {15'h0, bus.o_tx_valid}, 16'h0001);
        chk("push_empty_data", {8'h00, bus.o_tx_data}, 16'h00C3);
        bus.i_tx_ready = 1'b1;
        tick();
        bus.i_tx_ready = 1'b0;

        // 6. Asynchronous reset mid-run
        wr(16'hFF02, 16'h0000);
        wr(16'hFF03, 16'h0003);
        for (int i = 0; i < 3; i++) wr(16'hFF05, 16'(8'hE0 + i));
        repeat (95) tick();
        rd(16'hFF00);
        chk("pre_rst_rd", bus.o_ldst_rddata, 16'h1111);
        chk("pre_rst_valid", {15'h0, bus.o_tx_valid}, 16'h0001);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_rddata", bus.o_ldst_rddata, 16'h0000);
        chk("arst_gpio", bus.o_gpio, 16'h0000);
        chk("arst_txvalid", {15'h0, bus.o_tx_valid}, 16'h0000);
        chk("arst_txdata", {8'h00, bus.o_tx_data}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        rd(16'hFF01);
        chk("post_rst_count", bus.o_ldst_rddata, 16'h0000);
        rd(16'hFF03);
        chk("post_rst_ctrl", bus.o_ldst_rddata, 16'h0000);
        rd(16'hFF04);
        chk("post_rst_status", bus.o_ldst_rddata, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
